// File: rtl/arinc429_tx_scheduler.sv
// Round-robin scheduler sharing one ARINC 429 TX engine among N_REQ word sources.
// Define ARINC429_PARITY_EN to generate odd parity into bit 31 of the outgoing word.
module arinc429_tx_scheduler #(
  parameter int N_REQ    = 4,
  parameter int DIV_HI   = 500,
  parameter int DIV_LO   = 4000,
  parameter int GAP_BITS = 4,
  parameter int ACK_TMO  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_speed,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*32-1:0]   i_word,
  output logic [N_REQ-1:0]      o_gnt,
  output logic                  o_tx_start,
  output logic [31:0]           o_tx_word,
  output logic                  o_tx_speed,
  input  logic                  i_tx_busy,
  output logic [2:0]            o_cur_src,
  output logic                  o_idle,
  output logic                  o_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int GAP_W = $clog2(GAP_BITS*DIV_LO+1);
  localparam int ACK_W = $clog2(ACK_TMO+1);
  localparam logic [GAP_W-1:0] GAP_LD_HI = GAP_W'(GAP_BITS*DIV_HI-1);
  localparam logic [GAP_W-1:0] GAP_LD_LO = GAP_W'(GAP_BITS*DIV_LO-1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARB      = 3'd1,
    ST_LOAD     = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_TX       = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  state_t             state_r;
  logic [2:0]         ptr_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic [ACK_W-1:0]   ack_cnt_r;

  logic [N_REQ-1:0]   rot_s;
  logic [2:0]         win_off_s;
  logic [3:0]         sum_s;
  logic [2:0]         win_idx_s;
  logic [2:0]         ptr_nxt_s;
  logic               win_vld_s;
  logic [N_REQ-1:0]   gnt_s;
  logic [255:0]       word_pad_s;
  logic [31:0]        word_sel_s;
  logic [GAP_W-1:0]   gap_ld_s;

  function automatic logic [31:0] apply_parity(input logic [31:0] w);
`ifdef ARINC429_PARITY_EN
    apply_parity = {~^w[30:0], w[30:0]};
`else
    apply_parity = w;
`endif
  endfunction

  // Rotating-priority search: lowest set request at or above the RR pointer wins
  always_comb begin
    rot_s     = N_REQ'({i_req, i_req} >> ptr_r);
    win_off_s = 3'd0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      win_off_s = rot_s[k[IDX_W-1:0]] ? 3'(k) : win_off_s;
    end
    sum_s      = {1'b0, ptr_r} + {1'b0, win_off_s};
    win_idx_s  = (sum_s >= 4'(N_REQ)) ? 3'(sum_s - 4'(N_REQ)) : sum_s[2:0];
    ptr_nxt_s  = (win_idx_s == 3'(N_REQ-1)) ? 3'd0 : win_idx_s + 3'd1;
    win_vld_s  = |i_req;
    gnt_s      = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
    word_pad_s = 256'(i_word);
    word_sel_s = word_pad_s[{win_idx_s, 5'd0} +: 32];
    gap_ld_s   = o_tx_speed ? GAP_LD_LO : GAP_LD_HI;
  end

  // Scheduler FSM with all outputs registered
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r    <= ST_IDLE;
      ptr_r      <= 3'd0;
      gap_cnt_r  <= '0;
      ack_cnt_r  <= '0;
      o_gnt      <= '0;
      o_tx_start <= 1'b0;
      o_tx_word  <= 32'd0;
      o_tx_speed <= 1'b0;
      o_cur_src  <= 3'd0;
      o_idle     <= 1'b1;
      o_err      <= 1'b0;
    end else begin
      o_gnt      <= '0;
      o_tx_start <= 1'b0;
      o_err      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_enable && win_vld_s) begin
            state_r <= ST_ARB;
            o_idle  <= 1'b0;
          end else begin
            o_idle  <= 1'b1;
          end
        end
        ST_ARB: begin
          if (win_vld_s) begin
            state_r    <= ST_LOAD;
            ptr_r      <= ptr_nxt_s;
            o_gnt      <= gnt_s;
            o_tx_start <= 1'b1;
            o_tx_word  <= apply_parity(word_sel_s);
            o_tx_speed <= i_speed;
            o_cur_src  <= win_idx_s;
            ack_cnt_r  <= '0;
          end else begin
            // request withdrawn before arbitration: back off without a grant
            state_r <= ST_IDLE;
            o_idle  <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_r   <= ST_WAIT_ACK;
          ack_cnt_r <= ACK_W'(1);
        end
        ST_WAIT_ACK: begin
          if (i_tx_busy) begin
            state_r <= ST_TX;
          end else if (ack_cnt_r == ACK_W'(ACK_TMO-1)) begin
            // engine never acknowledged: drop the word, still honour the gap
            o_err     <= 1'b1;
            state_r   <= ST_GAP;
            gap_cnt_r <= gap_ld_s;
          end else begin
            ack_cnt_r <= ack_cnt_r + ACK_W'(1);
          end
        end
        ST_TX: begin
          if (!i_tx_busy) begin
            state_r   <= ST_GAP;
            gap_cnt_r <= gap_ld_s;
          end else begin
            state_r   <= ST_TX;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == '0) begin
            state_r <= ST_IDLE;
            o_idle  <= 1'b1;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          o_idle  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arinc429_tx_scheduler.sv
// Randomized self-checking bench for arinc429_tx_scheduler against a transaction-level model.
`timescale 1ns/1ps
module tb_arinc429_tx_scheduler;
  localparam int N = 4, DHI = 8, DLO = 20, GB = 4, TMO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            spd_in = 1'b0;
  logic            busy = 1'b0;
  logic [N-1:0]    req = '0;
  logic [31:0]     words [N];
  logic [N*32-1:0] word_bus;
  logic [N-1:0]    gnt;
  logic            start, txs, idle, err;
  logic [31:0]     txw;
  logic [2:0]      cur;

  int vectors = 0;
  int miscompares = 0;
  int rr_ptr = 0;
  logic lat_spd = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    word_bus = '0;
    for (int k = 0; k < N; k++) word_bus[k*32 +: 32] = words[k];
  end

  arinc429_tx_scheduler #(.N_REQ(N), .DIV_HI(DHI), .DIV_LO(DLO), .GAP_BITS(GB), .ACK_TMO(TMO)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_speed(spd_in),
    .i_req(req), .i_word(word_bus), .o_gnt(gnt), .o_tx_start(start),
    .o_tx_word(txw), .o_tx_speed(txs), .i_tx_busy(busy), .o_cur_src(cur),
    .o_idle(idle), .o_err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef ARINC429_PARITY_EN
    return {~^w[30:0], w[30:0]};
`else
    return w;
`endif
  endfunction

  function automatic int gap_len(input logic s);
    return GB * (s ? DLO : DHI);
  endfunction

  function automatic int exp_winner();
    for (int k = 0; k < N; k++) begin
      if (req[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
    end
    return -1;
  endfunction

  // Ticks until o_tx_start is seen, or -1 once the budget runs out
  task automatic wait_start(input int budget, output int n);
    n = 0;
    while (start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (start !== 1'b1) n = -1;
  endtask

  task automatic check_next(input string tag, input int exp_n);
    int n;
    wait_start(exp_n + 10, n);
    check(tag, 32'(n), 32'(exp_n));
  endtask

  // Called on the tick where o_tx_start is visible
  task automatic grant_check(output int w, output logic [31:0] ew);
    logic [31:0] mask;
    w    = exp_winner();
    mask = (w >= 0) ? (32'd1 << w) : 32'd0;
    ew   = exp_word(words[(w >= 0) ? w : 0]);
    check("gnt", 32'(gnt), mask);
    check("tx_word", txw, ew);
    check("tx_speed", 32'(txs), 32'(spd_in));
    check("cur_src", 32'(cur), 32'(w));
    check("idle_busy", 32'(idle), 32'd0);
    lat_spd = spd_in;
    if (w >= 0) rr_ptr = (w + 1) % N;
  endtask

  task automatic engine_ok(input int ack_dly, input int hold, input logic [31:0] ew);
    bit err_seen = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      if (err === 1'b1) err_seen = 1'b1;
    end
    busy = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (err === 1'b1) err_seen = 1'b1;
    end
    check("no_err", 32'(err_seen), 32'd0);
    check("word_stable", txw, ew);
    busy = 1'b0;
  endtask

  task automatic engine_tmo();
    int n = 0;
    while (err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("err_lat", 32'(n), 32'(TMO));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_word"}, txw, 32'd0);
    check({tag, "_speed"}, 32'(txs), 32'd0);
    check({tag, "_cur"}, 32'(cur), 32'd0);
    check({tag, "_idle"}, 32'(idle), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    reset_checks("rst");
    rst_n = 1'b1;
    rr_ptr = 0;
  endtask

  initial begin
    int n, w, k;
    logic [31:0] ew;
    bit tmo;
    for (int i = 0; i < N; i++) words[i] = 32'd0;

    do_reset();

    // single source, fixed latency, then idle after exactly one gap
    en = 1'b1;
    words[2] = 32'h0000_00A5;
    req = 4'b0100;
    wait_start(10, n);
    check("lat_idle", 32'(n), 32'd2);
    grant_check(w, ew);
    req = 4'b0000;
    tick();
    check("gnt_pulse", 32'(gnt), 32'd0);
    check("start_pulse", 32'(start), 32'd0);
    engine_ok(0, 10, ew);
    repeat (gap_len(lat_spd)) tick();
    check("gap_not_idle", 32'(idle), 32'd0);
    tick();
    check("gap_idle", 32'(idle), 32'd1);

    // request withdrawn between IDLE and ARB: no grant
    tick();
    words[0] = $urandom;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    wait_start(6, n);
    check("withdraw_nogrant", 32'(n), 32'hFFFF_FFFF);
    check("withdraw_idle", 32'(idle), 32'd1);

    // round robin with all sources held, 35-cycle turnaround at high speed
    do_reset();
    for (int i = 0; i < N; i++) words[i] = $urandom;
    spd_in = 1'b0;
    req = 4'b1111;
    wait_start(10, n);
    check("lat_rr", 32'(n), 32'd2);
    for (int i = 0; i < 8; i++) begin
      grant_check(w, ew);
      check("rr_order", 32'(w), 32'(i % N));
      engine_ok(1, 10, ew);
      check_next("gap35", 35);
    end

    // randomized traffic: changing requests, speeds, ack delays and timeouts
    for (int t = 0; t < 30; t++) begin
      grant_check(w, ew);
      if (w >= 0) begin
        req[w] = 1'($urandom % 2);
        words[w] = $urandom;
      end
      if (req == '0) begin
        k = $urandom % N;
        req[k] = 1'b1;
        words[k] = $urandom;
      end
      spd_in = 1'($urandom % 2);
      tmo = ($urandom % 5) == 0;
      if (tmo) begin
        engine_tmo();
        check_next("gap_after_tmo", gap_len(lat_spd) + 2);
      end else begin
        engine_ok($urandom_range(0, 12), $urandom_range(2, 15), ew);
        check_next("gap_rand", gap_len(lat_spd) + 3);
      end
    end

    // enable dropped mid-word: word and gap finish, then no grants until re-enabled
    grant_check(w, ew);
    req = 4'b1111;
    en = 1'b0;
    engine_ok(2, 5, ew);
    repeat (gap_len(lat_spd)) tick();
    check("en_not_idle", 32'(idle), 32'd0);
    tick();
    check("en_idle", 32'(idle), 32'd1);
    wait_start(20, n);
    check("en_blocked", 32'(n), 32'hFFFF_FFFF);
    en = 1'b1;
    wait_start(10, n);
    check("en_resume_lat", 32'(n), 32'd2);

    // reset in the middle of a transmission
    grant_check(w, ew);
    busy = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    reset_checks("rst_mid");
    busy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    rr_ptr = 0;
    req = 4'b1010;
    wait_start(10, n);
    check("rst_lat", 32'(n), 32'd2);
    grant_check(w, ew);
    check("rst_gnt1", 32'(w), 32'd1);
    req = 4'b0000;
    engine_ok(1, 4, ew);
    repeat (gap_len(lat_spd) + 2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
